// File: rtl/rvvi_retire_buffer_if.sv
// rvvi_retire_buffer_if: per-hart/lane retire-event inputs, serialized event output and per-hart status.
interface rvvi_retire_buffer_if #(
    parameter int NHART  = 1,
    parameter int RETIRE = 1,
    parameter int XLEN   = 32,
    parameter int ILEN   = 32
);
    localparam int HW = NHART > 1 ? $clog2(NHART) : 1;
    logic [NHART*RETIRE-1:0]      in_valid;
    logic [NHART*RETIRE*64-1:0]   in_order;
    logic [NHART*RETIRE*XLEN-1:0] in_pc;
    logic [NHART*RETIRE*ILEN-1:0] in_insn;
    logic [NHART*RETIRE-1:0]      in_trap;
    logic [NHART*RETIRE*2-1:0]    in_mode;
    logic                         out_valid;
    logic                         out_ready;
    logic [HW-1:0]                out_hart;
    logic [63:0]                  out_order;
    logic [XLEN-1:0]              out_pc;
    logic [ILEN-1:0]              out_insn;
    logic                         out_trap;
    logic [1:0]                   out_mode;
    logic [NHART-1:0]             overflow;
    logic [NHART-1:0]             order_err;
    logic [NHART*16-1:0]          drop_cnt;
    modport master (
        output in_valid, in_order, in_pc, in_insn, in_trap, in_mode, out_ready,
        input  out_valid, out_hart, out_order, out_pc, out_insn, out_trap, out_mode,
        input  overflow, order_err, drop_cnt
    );
    modport slave (
        input  in_valid, in_order, in_pc, in_insn, in_trap, in_mode, out_ready,
        output out_valid, out_hart, out_order, out_pc, out_insn, out_trap, out_mode,
        output overflow, order_err, drop_cnt
    );
endinterface

// File: rtl/rvvi_retire_buffer.sv
// rvvi_retire_buffer: per-hart retire FIFOs serialized by a round-robin arbiter,
// with overflow/drop accounting and per-hart order-gap detection.
module rvvi_retire_buffer #(
    parameter int NHART  = 1,
    parameter int RETIRE = 1,
    parameter int XLEN   = 32,
    parameter int ILEN   = 32,
    parameter int DEPTH  = 8
) (
    input logic                 clk,
    input logic                 reset,
    rvvi_retire_buffer_if.slave bus
);
    localparam int HW = NHART > 1 ? $clog2(NHART) : 1;
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int NW = $clog2(RETIRE + 1);
    localparam logic [AW-1:0] MASK = AW'(DEPTH - 1);

    logic [63:0]     ord_m  [NHART][DEPTH];
    logic [XLEN-1:0] pc_m   [NHART][DEPTH];
    logic [ILEN-1:0] insn_m [NHART][DEPTH];
    logic [1:0]      mode_m [NHART][DEPTH];
    logic            trap_m [NHART][DEPTH];

    logic [AW-1:0]    wp_q [NHART], wp_d [NHART];
    logic [AW-1:0]    rp_q [NHART], rp_d [NHART];
    logic [CW-1:0]    cnt_q [NHART], cnt_d [NHART];
    logic [63:0]      exp_q [NHART], exp_d [NHART];
    logic [15:0]      dc_q [NHART], dc_d [NHART];
    logic [16:0]      dsum [NHART];
    logic [NHART-1:0] seen_q, seen_d, ovf_q, ovf_d, oerr_q, oerr_d;
    logic [HW-1:0]    gnt_q, gnt_d, lock_h_q, lock_h_d, sel;
    logic             lock_q, lock_d, found, xfer;
    logic [NW-1:0]    n [NHART];
    logic [AW-1:0]    slot [NHART][RETIRE];
    logic [NHART-1:0] acc, ne, pop;

    // Valid lanes pack into consecutive slots; space is judged before this cycle's pop.
    always_comb begin
        for (int h = 0; h < NHART; h++) begin
            int k;
            k = 0;
            for (int r = 0; r < RETIRE; r++) begin
                slot[h][r] = (wp_q[h] + AW'(k)) & MASK;
                k = k + int'(bus.in_valid[h*RETIRE+r]);
            end
            n[h]   = NW'(k);
            acc[h] = DEPTH - int'(cnt_q[h]) >= k;
            ne[h]  = cnt_q[h] != '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int h = 0; h < NHART; h++)
            for (int r = 0; r < RETIRE; r++)
                if (!reset && bus.in_valid[h*RETIRE+r] && acc[h]) begin
                    ord_m[h][slot[h][r]]  <= bus.in_order[(h*RETIRE+r)*64 +: 64];
                    pc_m[h][slot[h][r]]   <= bus.in_pc[(h*RETIRE+r)*XLEN +: XLEN];
                    insn_m[h][slot[h][r]] <= bus.in_insn[(h*RETIRE+r)*ILEN +: ILEN];
                    trap_m[h][slot[h][r]] <= bus.in_trap[h*RETIRE+r];
                    mode_m[h][slot[h][r]] <= bus.in_mode[(h*RETIRE+r)*2 +: 2];
                end
    end

    // A stalled grant is latched so a newly non-empty hart cannot steal the output.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 1; i <= NHART; i++)
            if (!found && ne[(int'(gnt_q) + i) % NHART]) begin
                sel   = HW'((int'(gnt_q) + i) % NHART);
                found = 1'b1;
            end
        if (lock_q)
            sel = lock_h_q;
    end

    assign xfer          = bus.out_valid && bus.out_ready;
    assign bus.out_valid = |ne;
    assign bus.out_hart  = sel;
    assign bus.out_order = ord_m[sel][rp_q[sel]];
    assign bus.out_pc    = pc_m[sel][rp_q[sel]];
    assign bus.out_insn  = insn_m[sel][rp_q[sel]];
    assign bus.out_trap  = trap_m[sel][rp_q[sel]];
    assign bus.out_mode  = mode_m[sel][rp_q[sel]];
    assign bus.overflow  = ovf_q;
    assign bus.order_err = oerr_q;
    for (genvar g = 0; g < NHART; g++) begin : g_dc
        assign bus.drop_cnt[g*16 +: 16] = dc_q[g];
    end

    always_comb begin
        gnt_d    = xfer ? sel : gnt_q;
        lock_d   = bus.out_valid && !bus.out_ready;
        lock_h_d = sel;
        for (int h = 0; h < NHART; h++) begin
            pop[h]    = xfer && sel == HW'(h);
            wp_d[h]   = acc[h] ? (wp_q[h] + AW'(n[h])) & MASK : wp_q[h];
            rp_d[h]   = pop[h] ? (rp_q[h] + AW'(1)) & MASK : rp_q[h];
            cnt_d[h]  = cnt_q[h] + (acc[h] ? CW'(n[h]) : CW'(0)) - CW'(pop[h]);
            dsum[h]   = {1'b0, dc_q[h]} + 17'(n[h]);
            dc_d[h]   = acc[h] ? dc_q[h] : (dsum[h][16] ? 16'hFFFF : dsum[h][15:0]);
            ovf_d[h]  = ovf_q[h] | !acc[h];
            seen_d[h] = seen_q[h] | pop[h];
            exp_d[h]  = pop[h] ? bus.out_order + 64'd1 : exp_q[h];
            oerr_d[h] = oerr_q[h] | (pop[h] && seen_q[h] && bus.out_order != exp_q[h]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int h = 0; h < NHART; h++) begin
                wp_q[h]  <= '0;
                rp_q[h]  <= '0;
                cnt_q[h] <= '0;
                exp_q[h] <= '0;
                dc_q[h]  <= '0;
            end
            seen_q   <= '0;
            ovf_q    <= '0;
            oerr_q   <= '0;
            gnt_q    <= HW'(NHART - 1);
            lock_q   <= 1'b0;
            lock_h_q <= '0;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
            exp_q    <= exp_d;
            dc_q     <= dc_d;
            seen_q   <= seen_d;
            ovf_q    <= ovf_d;
            oerr_q   <= oerr_d;
            gnt_q    <= gnt_d;
            lock_q   <= lock_d;
            lock_h_q <= lock_h_d;
        end
    end
endmodule
